// File: rtl/ram_bus_master_pkg.sv
// Shared constants and FSM encoding for the RAM bus initiator.
package ram_bus_master_pkg;

    localparam int DEF_ADDRESS_BUS_WIDTH = 13;
    localparam int DEF_DATA_BUS_WIDTH    = 32;
    localparam int DEF_FETCH_STRIDE      = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_F_ADDR2 = 3'd3,
        ST_F_DATA2 = 3'd4,
        ST_WR      = 3'd5
    } state_t;

endpackage

// File: rtl/ram_bus_master.sv
// Initiator for the single-port RAM bus: read, two-word fetch and write,
// hiding the RAM's registered read latency behind one response pulse.
module ram_bus_master
    import ram_bus_master_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = DEF_ADDRESS_BUS_WIDTH,
    parameter int DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
    parameter int FETCH_STRIDE      = DEF_FETCH_STRIDE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic                         req_fetch,
    input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
    output logic                         resp_valid,
    output logic [DATA_BUS_WIDTH-1:0]    resp_rdata,
    output logic [DATA_BUS_WIDTH-1:0]    resp_rdata2,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
    inout  wire  [DATA_BUS_WIDTH-1:0]    mem_data,
    output logic                         mem_read_not_write
);

    localparam logic [ADDRESS_BUS_WIDTH-1:0] STRIDE = ADDRESS_BUS_WIDTH'(FETCH_STRIDE);

    state_t                         r_state;
    logic                           r_req_ready;
    logic                           r_resp_valid;
    logic                           r_fetch;
    logic                           r_rnw;
    logic [ADDRESS_BUS_WIDTH-1:0]   r_address;
    logic [DATA_BUS_WIDTH-1:0]      r_wdata;
    logic [DATA_BUS_WIDTH-1:0]      r_rdata;
    logic [DATA_BUS_WIDTH-1:0]      r_rdata2;

    // Driver enable and RAM direction come from the same register, so the
    // master and the RAM can never drive the bus in the same cycle.
    assign mem_data = r_rnw ? {DATA_BUS_WIDTH{1'bz}} : r_wdata;

    assign req_ready          = r_req_ready;
    assign resp_valid         = r_resp_valid;
    assign resp_rdata         = r_rdata;
    assign resp_rdata2        = r_rdata2;
    assign mem_address        = r_address;
    assign mem_read_not_write = r_rnw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_fetch      <= 1'b0;
            r_rnw        <= 1'b1;
            r_address    <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_rdata2     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_address   <= req_addr;
                        if (req_write) begin
                            r_wdata <= req_wdata;
                            r_rnw   <= 1'b0;
                            r_state <= ST_WR;
                        end else if (req_fetch) begin
                            r_fetch <= 1'b1;
                            r_state <= ST_F_ADDR2;
                        end else begin
                            r_fetch <= 1'b0;
                            r_state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: r_state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    // Fetch ends here with the second word; word A was
                    // captured one cycle earlier in F_DATA2.
                    if (r_fetch)
                        r_rdata2 <= mem_data;
                    else
                        r_rdata <= mem_data;
                    r_resp_valid <= 1'b1;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                ST_F_ADDR2: begin
                    r_address <= r_address + STRIDE;
                    r_state   <= ST_F_DATA2;
                end
                ST_F_DATA2: begin
                    r_rdata <= mem_data;
                    r_state <= ST_RD_DATA;
                end
                ST_WR: begin
                    r_rnw        <= 1'b1;
                    r_resp_valid <= 1'b1;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_rnw       <= 1'b1;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master with a behavioural registered-read RAM.
module tb_ram_bus_master;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic          req_fetch;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic [DW-1:0] resp_rdata2;
    logic [AW-1:0] mem_address;
    wire  [DW-1:0] mem_data;
    logic          mem_read_not_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_bus_master #(
        .ADDRESS_BUS_WIDTH (AW),
        .DATA_BUS_WIDTH    (DW),
        .FETCH_STRIDE      (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_fetch          (req_fetch),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .resp_rdata2        (resp_rdata2),
        .mem_address        (mem_address),
        .mem_data           (mem_data),
        .mem_read_not_write (mem_read_not_write)
    );

    // Single-port RAM: samples address/direction on posedge, registered read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic          ram_load;

    function automatic logic [DW-1:0] init_val(input int i);
        case (i)
            16:      return 32'd20;
            4096:    return 32'h88;
            4098:    return 32'h10;
            8191:    return 32'h77;
            1:       return 32'h11;
            8190:    return 32'h55;
            0:       return 32'h66;
            default: return 32'hA5A5_0000 | DW'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_val(i);
        end else if (mem_read_not_write) begin
            ram_q <= ram[mem_address];
        end else begin
            ram[mem_address] <= mem_data;
        end
    end

    assign mem_data = mem_read_not_write ? ram_q : {DW{1'bz}};

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE (called at posedge+1) and wait for its
    // response; returns with the response cycle current.
    task automatic run_req(input logic w, input logic f, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat);
        req_write = w;
        req_fetch = f;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        if (w) begin
            chk("wr_bus_drive", mem_data, d);
            chk("wr_direction", {31'd0, mem_read_not_write}, 32'd0);
        end
        while (!resp_valid && lat < 10) begin
            if (!w) chk("rd_bus_released", {31'd0, mem_read_not_write}, 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no resp_valid expected pulse within 10 cycles");
        end
    endtask

    typedef struct {
        logic          w;
        logic          f;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_lat;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_rd2;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int lat;

        vecs[0] = '{1'b0, 1'b0, 13'd16,   32'h0,    2, 32'd20,    32'h0};
        vecs[1] = '{1'b0, 1'b1, 13'd4096, 32'h0,    3, 32'h88,    32'h10};
        vecs[2] = '{1'b1, 1'b0, 13'd48,   32'h2A,   1, 32'h88,    32'h10};
        vecs[3] = '{1'b0, 1'b0, 13'd48,   32'h0,    2, 32'h2A,    32'h10};
        vecs[4] = '{1'b0, 1'b1, 13'd8191, 32'h0,    3, 32'h77,    32'h11};
        vecs[5] = '{1'b1, 1'b1, 13'd8191, 32'hDEAD, 1, 32'h77,    32'h11};
        vecs[6] = '{1'b0, 1'b0, 13'd8191, 32'h0,    2, 32'hDEAD,  32'h11};
        vecs[7] = '{1'b0, 1'b1, 13'd8190, 32'h0,    3, 32'h55,    32'h66};

        reset     = 1'b1;
        ram_load  = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_fetch = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 ram_load = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        chk("rst_req_ready",   {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid",  {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata",  resp_rdata, 32'd0);
        chk("rst_resp_rdata2", resp_rdata2, 32'd0);
        chk("rst_mem_address", {19'd0, mem_address}, 32'd0);
        chk("rst_mem_rnw",     {31'd0, mem_read_not_write}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].w, vecs[i].f, vecs[i].addr, vecs[i].wdata, lat);
            $display("vec %0d: w=%0d f=%0d addr=%0d lat=%0d rdata=0x%0h rdata2=0x%0h",
                     i, vecs[i].w, vecs[i].f, vecs[i].addr, lat, resp_rdata, resp_rdata2);
            chk($sformatf("vec%0d_latency", i), DW'(lat), DW'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), resp_rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d_rdata2", i), resp_rdata2, vecs[i].exp_rd2);
            chk($sformatf("vec%0d_ready_in_resp", i), {31'd0, req_ready}, 32'd1);
            chk($sformatf("vec%0d_bus_released", i), {31'd0, mem_read_not_write}, 32'd1);
        end

        // req_valid held high with changing requests during a fetch.
        @(posedge clk); #1;
        req_write = 1'b0; req_fetch = 1'b1; req_addr = 13'd4096; req_valid = 1'b1;
        @(posedge clk); #1;
        chk("hold_addr_e0", {19'd0, mem_address}, 32'd4096);
        chk("hold_busy_e0", {31'd0, req_ready}, 32'd0);
        req_fetch = 1'b0; req_addr = 13'd100;
        @(posedge clk); #1;
        chk("hold_addr2_e1", {19'd0, mem_address}, 32'd4098);
        req_addr = 13'd200;
        @(posedge clk); #1;
        chk("hold_no_resp_e2", {31'd0, resp_valid}, 32'd0);
        req_addr = 13'd16;
        @(posedge clk); #1;
        chk("hold_resp_e3", {31'd0, resp_valid}, 32'd1);
        chk("hold_rdata_e3", resp_rdata, 32'h88);
        chk("hold_rdata2_e3", resp_rdata2, 32'h10);
        chk("hold_ready_e3", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold_pulse_end_e4", {31'd0, resp_valid}, 32'd0);
        chk("hold_next_addr_e4", {19'd0, mem_address}, 32'd16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_next_resp_e6", {31'd0, resp_valid}, 32'd1);
        chk("hold_next_rdata_e6", resp_rdata, 32'd20);
        $display("hold-valid sequence: second read rdata=0x%0h", resp_rdata);

        // Reset while in F_DATA2 aborts the fetch.
        @(posedge clk); #1;
        req_fetch = 1'b1; req_addr = 13'd4096; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_resp_valid",  {31'd0, resp_valid}, 32'd0);
        chk("abort_req_ready",   {31'd0, req_ready}, 32'd1);
        chk("abort_rdata",       resp_rdata, 32'd0);
        chk("abort_rdata2",      resp_rdata2, 32'd0);
        chk("abort_mem_address", {19'd0, mem_address}, 32'd0);
        chk("abort_mem_rnw",     {31'd0, mem_read_not_write}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_no_late_resp", {31'd0, resp_valid}, 32'd0);
        end
        run_req(1'b0, 1'b0, 13'd16, 32'h0, lat);
        $display("post-reset read: lat=%0d rdata=0x%0h", lat, resp_rdata);
        chk("post_reset_latency", DW'(lat), 32'd2);
        chk("post_reset_rdata", resp_rdata, 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_bus_master.md
# ram_bus_master

Initiator side of the single-port RAM bus. Accepts word read, two-word instruction fetch and word write requests from the control unit over a valid/ready handshake. Drives `mem_address` and `mem_read_not_write`, and drives or releases the shared tri-state `mem_data` bus. It also owns the RAM's one-cycle registered read latency, so the datapath sees a single response pulse.

## Interface
Parameters (defaults come from `params.v`):
- `ADDRESS_BUS_WIDTH`, 13, word address width.
- `DATA_BUS_WIDTH`, 32, data word width.
- `FETCH_STRIDE`, 2, address offset of the second instruction word.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: block idle; a request is accepted on a posedge when `req_valid && req_ready`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_fetch` input 1: with `req_write`=0, read two words at A and A+FETCH_STRIDE. Ignored when `req_write`=1.
- `req_addr` input ADDRESS_BUS_WIDTH: address A.
- `req_wdata` input DATA_BUS_WIDTH: write data.
- `resp_valid` output 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` output DATA_BUS_WIDTH: word at A.
- `resp_rdata2` output DATA_BUS_WIDTH: word at A+FETCH_STRIDE (fetch only).
- `mem_address` output ADDRESS_BUS_WIDTH: to RAM `address`.
- `mem_data` inout DATA_BUS_WIDTH: to RAM `data`.
- `mem_read_not_write` output 1: to RAM `read_not_write`.

## Operation
- The RAM samples address and direction on posedge. A read word appears on `mem_data` after the following posedge and remains while `read_not_write`=1.
- Bus drive rules:
  - `mem_data` is driven only when the registered `mem_read_not_write` is 0; otherwise it is high-Z.
  - Direction and driver enable derive from the same register, so there is no contention.
- FSM states: IDLE, RD_ADDR, RD_DATA, F_ADDR2, F_DATA2, WR.
- IDLE: `req_ready`=1, `mem_read_not_write`=1, address held. On accept:
  - write: register A/wdata, `mem_read_not_write`<=0, go to WR.
  - read: `mem_address`<=A, go to RD_ADDR.
  - fetch: `mem_address`<=A, go to F_ADDR2.
- RD_ADDR: go to RD_DATA.
- RD_DATA: capture `mem_data` into `resp_rdata`, pulse `resp_valid`, go to IDLE.
- F_ADDR2: `mem_address`<=A+FETCH_STRIDE; the RAM samples A on this same edge. Go to F_DATA2.
- F_DATA2: capture word A into `resp_rdata`, then go to RD_DATA. There it captures word A+2 into `resp_rdata2`, and `resp_rdata` is held.
- WR: the RAM writes at the exit edge. `mem_read_not_write`<=1, pulse `resp_valid`, go to IDLE.
- Address arithmetic is modulo 2^ADDRESS_BUS_WIDTH; A+2 wraps silently.
- `req_*` is ignored whenever `req_ready`=0.
- `resp_rdata`/`resp_rdata2` hold their values until the next capture. A write does not change them.

## Timing
- Acceptance edge is E0. `resp_valid` is high in cycle:
  - read: E2–E3 (latency 2).
  - fetch: E3–E4 (latency 3).
  - write: E1–E2 (latency 1).
- `req_ready` returns high in the same cycle `resp_valid` is high, so back-to-back accept is allowed.
- Write followed immediately by a read of the same address returns the new data.
- Reset values:
  - state IDLE
  - `req_ready`=1
  - `resp_valid`=0
  - `resp_rdata`=`resp_rdata2`=0
  - `mem_address`=0
  - `mem_read_not_write`=1 (bus released)
- Reset mid-operation aborts with no `resp_valid`. A write whose WR exit coincides with the reset edge still commits in the RAM.

## Structure
- `params.v` (shared): state encodings and `FETCH_STRIDE`, alongside the existing bus width constants.
- No sub-module. The tri-state driver is a single continuous assignment.
- The FSM, address/data registers and response registers live in one module.

## Test plan
- RAM preloaded with mem[16]=20. Read A=16 → `resp_valid` at E2, `resp_rdata`=20, bus never driven by the master.
- Fetch A=4096 (mem[4096]=0x88, mem[4098]=0x10) → at E3, `resp_rdata`=0x88, `resp_rdata2`=0x10.
- Write A=48 data 0x2A, then an immediate read A=48 → write ack at E1, read returns 0x2A. `mem_data` is high-Z except during WR.
- Fetch at A=2^13-1 → second access at address 1, with wrap-around data returned.
- `req_valid` held high with changing addresses during a fetch → only the first request is accepted. Next accept occurs in the `resp_valid` cycle.
- Reset asserted in F_DATA2 → no `resp_valid`; all outputs at reset values next cycle; a following read works normally.
